// File: rtl/i2c_byte_master_if.sv
// rtl/i2c_byte_master_if.sv - command/response and phy primitive bundle for i2c_byte_master
interface i2c_byte_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_start;
  logic       cmd_write;
  logic       cmd_read;
  logic       cmd_stop;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       rsp_error;
  logic       phy_start_bit;
  logic       phy_write_bit;
  logic       phy_read_bit;
  logic       phy_stop_bit;
  logic       phy_tx_data;
  logic       phy_release_bus;
  logic       phy_rx_data;
  logic [4:0] phy_state;
  logic       bus_control;
  logic       busy;

  modport master (
    input  cmd_valid, cmd_start, cmd_write, cmd_read, cmd_stop, cmd_data, cmd_nack,
    input  phy_rx_data, phy_state, bus_control,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack, rsp_error,
    output phy_start_bit, phy_write_bit, phy_read_bit, phy_stop_bit, phy_tx_data,
    output phy_release_bus, busy
  );

  modport slave (
    output cmd_valid, cmd_start, cmd_write, cmd_read, cmd_stop, cmd_data, cmd_nack,
    output phy_rx_data, phy_state, bus_control,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack, rsp_error,
    input  phy_start_bit, phy_write_bit, phy_read_bit, phy_stop_bit, phy_tx_data,
    input  phy_release_bus, busy
  );
endinterface

// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - byte-level I2C master sequencer issuing single-bit phy primitives
// with a per-primitive watchdog that releases the bus on a stalled phy.
module i2c_byte_master #(
  parameter logic [19:0] WATCHDOG = 20'hFFFFF
) (
  input logic               clk,
  input logic               rst,
  i2c_byte_master_if.master bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, CHECK = 3'd1, ISSUE = 3'd2, WAIT_DONE = 3'd3, RESP = 3'd4, ABORT = 3'd5
  } state_t;
  typedef enum logic [1:0] {PH_START = 2'd0, PH_BYTE = 2'd1, PH_STOP = 2'd2} phase_t;

  localparam logic [4:0]  PHY_IDLE   = 5'd0;
  localparam logic [4:0]  PHY_ACTIVE = 5'd1;
  localparam logic [19:0] WD_LIMIT   = (WATCHDOG == 20'd0) ? 20'd1 : WATCHDOG;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d, phase_nxt;
  logic [3:0]  idx_q, idx_d;
  logic        start_q, start_d, wr_q, wr_d, rd_q, rd_d, stop_q, stop_d;
  logic [7:0]  data_q, data_d;
  logic        ack_q, ack_d;
  logic [4:0]  ref_q, ref_d;
  logic [19:0] wd_q, wd_d;
  logic [6:0]  sh_q, sh_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_nack_q, rsp_nack_d;
  logic        rsp_error_q, rsp_error_d;
  logic        release_q, release_d;

  logic in_ack, p_start, p_stop, p_wbit, p_rbit, tx_bit;
  logic prim_done, accepted, wd_expired, reject, more, handshake;
  logic unused_bus_control;

  assign unused_bus_control = bus.bus_control;
  assign handshake          = bus.cmd_valid & bus.cmd_ready;

  // Decode the current primitive; idx==8 is the ACK slot, whose direction is opposite the byte.
  always_comb begin
    in_ack     = (idx_q == 4'd8);
    p_start    = (phase_q == PH_START);
    p_stop     = (phase_q == PH_STOP);
    p_wbit     = (phase_q == PH_BYTE) & (wr_q ^ in_ack);
    p_rbit     = (phase_q == PH_BYTE) & ~(wr_q ^ in_ack);
    tx_bit     = in_ack ? ack_q : data_q[3'd7 - idx_q[2:0]];
    prim_done  = p_stop ? (bus.phy_state == PHY_IDLE) : (bus.phy_state == PHY_ACTIVE);
    accepted   = (bus.phy_state != ref_q);
    wd_expired = (wd_q >= WD_LIMIT);
    reject     = (wr_q & rd_q) | ~(start_q | wr_q | rd_q | stop_q)
               | (~start_q & (bus.phy_state == PHY_IDLE));
    more       = 1'b0;
    phase_nxt  = phase_q;
    case (phase_q)
      PH_START: begin
        if (wr_q | rd_q) begin
          phase_nxt = PH_BYTE;
          more      = 1'b1;
        end else if (stop_q) begin
          phase_nxt = PH_STOP;
          more      = 1'b1;
        end
      end
      PH_BYTE: begin
        if (!in_ack) begin
          more = 1'b1;
        end else if (stop_q) begin
          phase_nxt = PH_STOP;
          more      = 1'b1;
        end
      end
      default: more = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= PH_START;
      idx_q       <= 4'd0;
      start_q     <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      stop_q      <= 1'b0;
      data_q      <= 8'h00;
      ack_q       <= 1'b0;
      ref_q       <= 5'd0;
      wd_q        <= 20'd0;
      sh_q        <= 7'd0;
      rsp_data_q  <= 8'h00;
      rsp_nack_q  <= 1'b0;
      rsp_error_q <= 1'b0;
      release_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      start_q     <= start_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      stop_q      <= stop_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      ref_q       <= ref_d;
      wd_q        <= wd_d;
      sh_q        <= sh_d;
      rsp_data_q  <= rsp_data_d;
      rsp_nack_q  <= rsp_nack_d;
      rsp_error_q <= rsp_error_d;
      release_q   <= release_d;
    end
  end

  // Completion beats the watchdog, and acceptance beats it in ISSUE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (handshake) state_d = CHECK;
      CHECK:     state_d = reject ? RESP : ISSUE;
      ISSUE: begin
        if (accepted)        state_d = WAIT_DONE;
        else if (wd_expired) state_d = ABORT;
      end
      WAIT_DONE: begin
        if (prim_done)       state_d = more ? ISSUE : RESP;
        else if (wd_expired) state_d = ABORT;
      end
      RESP:      state_d = IDLE;
      ABORT:     state_d = RESP;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    phase_d     = phase_q;
    idx_d       = idx_q;
    start_d     = start_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    stop_d      = stop_q;
    data_d      = data_q;
    ack_d       = ack_q;
    ref_d       = ref_q;
    wd_d        = wd_q;
    sh_d        = sh_q;
    rsp_data_d  = rsp_data_q;
    rsp_nack_d  = rsp_nack_q;
    rsp_error_d = rsp_error_q;
    release_d   = (state_d == ABORT);

    if (state_q == IDLE && handshake) begin
      start_d     = bus.cmd_start;
      wr_d        = bus.cmd_write;
      rd_d        = bus.cmd_read;
      stop_d      = bus.cmd_stop;
      data_d      = bus.cmd_data;
      ack_d       = bus.cmd_nack;
      idx_d       = 4'd0;
      rsp_nack_d  = 1'b0;
      rsp_error_d = 1'b0;
    end

    if (state_q == CHECK) begin
      phase_d = start_q ? PH_START : ((wr_q | rd_q) ? PH_BYTE : PH_STOP);
      if (reject) rsp_error_d = 1'b1;
    end

    if (state_d == ISSUE && state_q != ISSUE) begin
      ref_d = bus.phy_state;
      wd_d  = 20'd0;
    end else if (state_d == WAIT_DONE && state_q != WAIT_DONE) begin
      wd_d = 20'd0;
    end else if (state_q == ISSUE || state_q == WAIT_DONE) begin
      wd_d = wd_q + 20'd1;
    end

    if (state_q == WAIT_DONE && prim_done) begin
      if (p_rbit && !in_ack) begin
        sh_d = {sh_q[5:0], bus.phy_rx_data};
        if (idx_q == 4'd7) rsp_data_d = {sh_q, bus.phy_rx_data};
      end
      if (p_rbit && in_ack) rsp_nack_d = bus.phy_rx_data;
      if (more) begin
        if (phase_q == PH_BYTE && !in_ack) idx_d = idx_q + 4'd1;
        else                               phase_d = phase_nxt;
      end
    end

    if (state_q == ABORT) rsp_error_d = 1'b1;
  end

  always_comb begin
    bus.cmd_ready       = (state_q == IDLE) & ~rst;
    bus.busy            = (state_q != IDLE);
    bus.rsp_valid       = (state_q == RESP);
    bus.rsp_data        = rsp_data_q;
    bus.rsp_nack        = rsp_nack_q;
    bus.rsp_error       = rsp_error_q;
    bus.phy_start_bit   = (state_q == ISSUE) & p_start;
    bus.phy_write_bit   = (state_q == ISSUE) & p_wbit;
    bus.phy_read_bit    = (state_q == ISSUE) & p_rbit;
    bus.phy_stop_bit    = (state_q == ISSUE) & p_stop;
    bus.phy_tx_data     = (state_q == ISSUE) & p_wbit & tx_bit;
    bus.phy_release_bus = release_q;
  end
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb/tb_i2c_byte_master.sv - directed bench for i2c_byte_master with a behavioural bit-level phy
module tb_i2c_byte_master;
  localparam int PRESCALE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_byte_master_if bif ();
  i2c_byte_master #(.WATCHDOG(20'd64)) dut (.clk(clk), .rst(rst), .bus(bif));

  int vectors = 0;
  int miscompares = 0;

  // Phy model: 0 idle, 1 active, 2 busy with a primitive; completes PRESCALE cycles after accept.
  logic [4:0] ps = 5'd0;
  logic       rx = 1'b0;
  logic       bc = 1'b0;
  assign bif.phy_state   = ps;
  assign bif.phy_rx_data = rx;
  assign bif.bus_control = bc;

  int   cnt = 0, kind = 0, rk = 0;
  bit   stalled = 1'b0;
  bit   stall_wbit = 1'b0;
  int   n_start = 0, n_stop = 0, n_wbit = 0, n_rbit = 0;
  int   multi = 0, strobe_total = 0, rsp_pulses = 0;
  bit   wlog[$];
  logic [0:8] slave_seq = 9'h1FF;
  int   slave_base = 0;

  always @(negedge clk) begin : phy_model
    int ns;
    ns = int'(bif.phy_start_bit) + int'(bif.phy_write_bit) + int'(bif.phy_read_bit) + int'(bif.phy_stop_bit);
    if (ns > 1) multi++;
    if (ns > 0) strobe_total++;
    if (bif.rsp_valid === 1'b1) rsp_pulses++;
    if (bif.phy_release_bus === 1'b1) begin
      ps = 5'd0; bc = 1'b0; stalled = 1'b0;
    end else if (ps == 5'd2) begin
      if (!stalled) begin
        if (cnt > 0) cnt--;
        else begin
          if (kind == 3) begin ps = 5'd0; bc = 1'b0; end
          else begin ps = 5'd1; bc = 1'b1; end
          if (kind == 2) rx = (rk >= 0 && rk < 9) ? slave_seq[rk] : 1'b1;
        end
      end
    end else if (ns > 0) begin
      ps = 5'd2; cnt = PRESCALE;
      if (bif.phy_start_bit) begin kind = 0; n_start++; end
      else if (bif.phy_write_bit) begin
        kind = 1; wlog.push_back(bif.phy_tx_data); n_wbit++;
        if (stall_wbit) stalled = 1'b1;
      end else if (bif.phy_read_bit) begin kind = 2; rk = n_rbit - slave_base; n_rbit++; end
      else begin kind = 3; n_stop++; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] wbyte(input int base);
    logic [7:0] b;
    b = 8'hxx;
    if (wlog.size() >= base + 8)
      for (int i = 0; i < 8; i++) b[7-i] = wlog[base+i];
    return b;
  endfunction

  task automatic run_cmd(input logic s, w, r, p, input logic [7:0] d, input logic nk,
                         output int lat, output int fst, output logic rn, output logic re,
                         output logic [7:0] rd, output logic rdy_rsp, output logic rdy_after,
                         output int rel);
    int n;
    lat = 0; fst = 0; rel = 0; rn = 1'bx; re = 1'bx; rd = 8'hxx; rdy_rsp = 1'bx;
    bif.cmd_valid = 1'b1; bif.cmd_start = s; bif.cmd_write = w; bif.cmd_read = r;
    bif.cmd_stop = p; bif.cmd_data = d; bif.cmd_nack = nk;
    n = 0;
    while (bif.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    bif.cmd_valid = 1'b0;
    n = 1;
    while (n < 400) begin
      if ((bif.phy_start_bit | bif.phy_write_bit | bif.phy_read_bit | bif.phy_stop_bit) && fst == 0) fst = n;
      if (bif.phy_release_bus === 1'b1) rel++;
      if (bif.rsp_valid === 1'b1) begin
        lat = n; rn = bif.rsp_nack; re = bif.rsp_error; rd = bif.rsp_data; rdy_rsp = bif.cmd_ready;
        break;
      end
      tick();
      n++;
    end
    tick();
    rdy_after = bif.cmd_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vectors++; if (bif.phy_release_bus !== 1'b1) begin miscompares++; $display("FAIL reset_release got=%b exp=1", bif.phy_release_bus); end
    vectors++; if (bif.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_ready got=%b exp=0", bif.cmd_ready); end
    vectors++; if (bif.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bif.busy); end
    vectors++; if (bif.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b exp=0", bif.rsp_valid); end
    vectors++; if (bif.rsp_data !== 8'h00) begin miscompares++; $display("FAIL reset_rsp_data got=%h exp=00", bif.rsp_data); end
    vectors++; if ({bif.phy_start_bit, bif.phy_write_bit, bif.phy_read_bit, bif.phy_stop_bit} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_strobes got=%b exp=0000", {bif.phy_start_bit, bif.phy_write_bit, bif.phy_read_bit, bif.phy_stop_bit}); end
    rst = 1'b0;
    #1;
    vectors++; if (bif.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after got=%b exp=1", bif.cmd_ready); end
    vectors++; if (bif.phy_release_bus !== 1'b1) begin miscompares++; $display("FAIL reset_release_hold got=%b exp=1", bif.phy_release_bus); end
    tick();
    vectors++; if (bif.phy_release_bus !== 1'b0) begin miscompares++; $display("FAIL reset_release_clear got=%b exp=0", bif.phy_release_bus); end
  endtask

  task automatic test_write_byte();
    int lat, fst, rel, wb, s0; logic rn, re, ra, rr; logic [7:0] rd;
    slave_seq = 9'b0_1111_1111; slave_base = n_rbit; wb = wlog.size(); s0 = n_start;
    run_cmd(1, 1, 0, 0, 8'hA5, 0, lat, fst, rn, re, rd, rr, ra, rel);
    vectors++; if (fst !== 2) begin miscompares++; $display("FAIL wr_first_strobe got=%0d exp=2", fst); end
    vectors++; if (lat == 0) begin miscompares++; $display("FAIL wr_rsp got=timeout exp=rsp_valid"); end
    vectors++; if (re !== 1'b0) begin miscompares++; $display("FAIL wr_error got=%b exp=0", re); end
    vectors++; if (rn !== 1'b0) begin miscompares++; $display("FAIL wr_nack got=%b exp=0", rn); end
    vectors++; if (wbyte(wb) !== 8'hA5) begin miscompares++; $display("FAIL wr_sda_bits got=%h exp=a5", wbyte(wb)); end
    vectors++; if (wlog.size() - wb !== 8) begin miscompares++; $display("FAIL wr_bit_count got=%0d exp=8", wlog.size() - wb); end
    vectors++; if (n_start - s0 !== 1) begin miscompares++; $display("FAIL wr_start_count got=%0d exp=1", n_start - s0); end
    vectors++; if (bc !== 1'b1) begin miscompares++; $display("FAIL wr_bus_control got=%b exp=1", bc); end
    vectors++; if (ra !== 1'b1) begin miscompares++; $display("FAIL wr_ready_after got=%b exp=1", ra); end
  endtask

  task automatic test_read_stop();
    int lat, fst, rel, wb, rb, p0; logic rn, re, ra, rr; logic [7:0] rd;
    slave_seq = 9'b0011_1100_0; slave_base = n_rbit; wb = wlog.size(); rb = n_rbit; p0 = n_stop;
    run_cmd(0, 0, 1, 1, 8'h00, 1, lat, fst, rn, re, rd, rr, ra, rel);
    vectors++; if (rd !== 8'h3C) begin miscompares++; $display("FAIL rd_data got=%h exp=3c", rd); end
    vectors++; if (re !== 1'b0) begin miscompares++; $display("FAIL rd_error got=%b exp=0", re); end
    vectors++; if (n_rbit - rb !== 8) begin miscompares++; $display("FAIL rd_bit_count got=%0d exp=8", n_rbit - rb); end
    vectors++; if (wlog.size() - wb !== 1) begin miscompares++; $display("FAIL rd_ack_count got=%0d exp=1", wlog.size() - wb); end
    vectors++; if (wlog.size() > wb && wlog[wb] !== 1'b1) begin miscompares++; $display("FAIL rd_ack_level got=%b exp=1", wlog[wb]); end
    vectors++; if (n_stop - p0 !== 1) begin miscompares++; $display("FAIL rd_stop_count got=%0d exp=1", n_stop - p0); end
    vectors++; if (ps !== 5'd0) begin miscompares++; $display("FAIL rd_phy_state got=%0d exp=0", ps); end
    vectors++; if (bc !== 1'b0) begin miscompares++; $display("FAIL rd_bus_control got=%b exp=0", bc); end
  endtask

  task automatic test_reject_no_owner();
    int lat, fst, rel, st; logic rn, re, ra, rr; logic [7:0] rd;
    st = strobe_total;
    run_cmd(0, 1, 0, 0, 8'hFF, 0, lat, fst, rn, re, rd, rr, ra, rel);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL noown_latency got=%0d exp=2", lat); end
    vectors++; if (re !== 1'b1) begin miscompares++; $display("FAIL noown_error got=%b exp=1", re); end
    vectors++; if (strobe_total - st !== 0) begin miscompares++; $display("FAIL noown_strobes got=%0d exp=0", strobe_total - st); end
    vectors++; if (rd !== 8'h3C) begin miscompares++; $display("FAIL noown_rsp_data_hold got=%h exp=3c", rd); end
    run_cmd(0, 0, 0, 1, 8'h00, 0, lat, fst, rn, re, rd, rr, ra, rel);
    vectors++; if (lat !== 2 || re !== 1'b1) begin miscompares++; $display("FAIL noown_stop got=lat%0d/err%b exp=lat2/err1", lat, re); end
  endtask

  task automatic test_reject_flags();
    int lat, fst, rel, st, s0; logic rn, re, ra, rr; logic [7:0] rd;
    st = strobe_total;
    run_cmd(1, 1, 1, 0, 8'h12, 0, lat, fst, rn, re, rd, rr, ra, rel);
    vectors++; if (lat !== 2 || re !== 1'b1) begin miscompares++; $display("FAIL wrrd_reject got=lat%0d/err%b exp=lat2/err1", lat, re); end
    run_cmd(0, 0, 0, 0, 8'h00, 0, lat, fst, rn, re, rd, rr, ra, rel);
    vectors++; if (lat !== 2 || re !== 1'b1) begin miscompares++; $display("FAIL noflag_reject got=lat%0d/err%b exp=lat2/err1", lat, re); end
    vectors++; if (strobe_total - st !== 0) begin miscompares++; $display("FAIL reject_strobes got=%0d exp=0", strobe_total - st); end
    s0 = n_start;
    run_cmd(1, 0, 0, 0, 8'h00, 0, lat, fst, rn, re, rd, rr, ra, rel);
    vectors++; if (lat == 0 || re !== 1'b0) begin miscompares++; $display("FAIL start_only got=lat%0d/err%b exp=rsp/err0", lat, re); end
    vectors++; if (n_start - s0 !== 1 || ps !== 5'd1) begin miscompares++; $display("FAIL start_only_phy got=starts%0d/state%0d exp=1/1", n_start - s0, ps); end
  endtask

  task automatic test_watchdog();
    int lat, fst, rel, wb; logic rn, re, ra, rr; logic [7:0] rd;
    stall_wbit = 1'b1; wb = wlog.size();
    run_cmd(1, 1, 0, 0, 8'hC3, 0, lat, fst, rn, re, rd, rr, ra, rel);
    stall_wbit = 1'b0;
    vectors++; if (re !== 1'b1) begin miscompares++; $display("FAIL wd_error got=%b exp=1", re); end
    vectors++; if (rel !== 1) begin miscompares++; $display("FAIL wd_release_width got=%0d exp=1", rel); end
    vectors++; if (ra !== 1'b1) begin miscompares++; $display("FAIL wd_ready_after got=%b exp=1", ra); end
    vectors++; if (ps !== 5'd0) begin miscompares++; $display("FAIL wd_phy_state got=%0d exp=0", ps); end
    vectors++; if (wlog.size() - wb !== 1) begin miscompares++; $display("FAIL wd_bits_issued got=%0d exp=1", wlog.size() - wb); end
  endtask

  task automatic test_reset_mid_cmd();
    int n, base, rp, lat, fst, rel, wb; logic rn, re, ra, rr; logic [7:0] rd;
    base = n_wbit;
    bif.cmd_valid = 1'b1; bif.cmd_start = 1'b1; bif.cmd_write = 1'b1; bif.cmd_read = 1'b0;
    bif.cmd_stop = 1'b0; bif.cmd_data = 8'h5A; bif.cmd_nack = 1'b0;
    tick();
    bif.cmd_valid = 1'b0;
    n = 0;
    while (n_wbit - base < 4 && n < 200) begin tick(); n++; end
    vectors++; if (n_wbit - base < 4) begin miscompares++; $display("FAIL rstmid_reach_bit3 got=%0d exp>=4", n_wbit - base); end
    rp = rsp_pulses;
    rst = 1'b1;
    tick();
    vectors++; if ({bif.phy_start_bit, bif.phy_write_bit, bif.phy_read_bit, bif.phy_stop_bit} !== 4'b0000) begin
      miscompares++; $display("FAIL rstmid_strobes got=%b exp=0000", {bif.phy_start_bit, bif.phy_write_bit, bif.phy_read_bit, bif.phy_stop_bit}); end
    vectors++; if (bif.phy_release_bus !== 1'b1 || bif.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_release_busy got=%b%b exp=10", bif.phy_release_bus, bif.busy); end
    tick();
    rst = 1'b0;
    #1;
    vectors++; if (bif.phy_release_bus !== 1'b1) begin miscompares++; $display("FAIL rstmid_release_after got=%b exp=1", bif.phy_release_bus); end
    tick();
    vectors++; if (bif.phy_release_bus !== 1'b0) begin miscompares++; $display("FAIL rstmid_release_clear got=%b exp=0", bif.phy_release_bus); end
    repeat (3) tick();
    vectors++; if (rsp_pulses !== rp) begin miscompares++; $display("FAIL rstmid_no_rsp got=%0d exp=%0d", rsp_pulses, rp); end
    slave_seq = 9'b0_1111_1111; slave_base = n_rbit; wb = wlog.size();
    run_cmd(1, 1, 0, 1, 8'h81, 0, lat, fst, rn, re, rd, rr, ra, rel);
    vectors++; if (lat == 0 || re !== 1'b0) begin miscompares++; $display("FAIL rstmid_next_cmd got=lat%0d/err%b exp=rsp/err0", lat, re); end
    vectors++; if (wbyte(wb) !== 8'h81 || ps !== 5'd0) begin miscompares++; $display("FAIL rstmid_next_bits got=%h/state%0d exp=81/0", wbyte(wb), ps); end
  endtask

  task automatic test_back_to_back();
    int lat, fst, rel, wb; logic rn, re, ra, rr; logic [7:0] rd;
    slave_seq = 9'b1_1111_1111; slave_base = n_rbit;
    run_cmd(1, 1, 0, 0, 8'h00, 0, lat, fst, rn, re, rd, rr, ra, rel);
    vectors++; if (rn !== 1'b1 || re !== 1'b0) begin miscompares++; $display("FAIL b2b_nack got=nack%b/err%b exp=1/0", rn, re); end
    vectors++; if (rr !== 1'b0 || ra !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got=%b%b exp=01", rr, ra); end
    slave_seq = 9'b0_1111_1111; slave_base = n_rbit; wb = wlog.size();
    run_cmd(0, 1, 0, 1, 8'hFF, 0, lat, fst, rn, re, rd, rr, ra, rel);
    vectors++; if (rn !== 1'b0 || re !== 1'b0 || fst !== 2) begin miscompares++; $display("FAIL b2b_second got=nack%b/err%b/first%0d exp=0/0/2", rn, re, fst); end
    vectors++; if (wbyte(wb) !== 8'hFF || ps !== 5'd0) begin miscompares++; $display("FAIL b2b_second_bits got=%h/state%0d exp=ff/0", wbyte(wb), ps); end
  endtask

  task automatic test_strobe_exclusive();
    vectors++; if (multi !== 0) begin miscompares++; $display("FAIL strobe_exclusive got=%0d exp=0", multi); end
  endtask

  initial begin
    rst = 1'b1;
    bif.cmd_valid = 1'b0; bif.cmd_start = 1'b0; bif.cmd_write = 1'b0; bif.cmd_read = 1'b0;
    bif.cmd_stop = 1'b0; bif.cmd_data = 8'h00; bif.cmd_nack = 1'b0;
    test_reset();
    test_write_byte();
    test_read_stop();
    test_reject_no_owner();
    test_reject_flags();
    test_watchdog();
    test_reset_mid_cmd();
    test_back_to_back();
    test_strobe_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2c_byte_master.md
# i2c_byte_master

Byte-level I2C master sequencer sitting directly above `i2c_phy`. It accepts one command per handshake: optional START, optional byte write or read, optional STOP. It breaks each command into single-bit phy primitives (start, 8 data bits plus ACK bit, stop) and reports the result on a one-cycle response pulse. A watchdog releases the bus if the phy stalls, for example under indefinite clock stretching.

## Interface
- `WATCHDOG`, default 20'hFFFFF: max cycles to wait for any single phy primitive to be accepted or to complete; width 20.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: equals `(state==IDLE) & ~rst`.
- `cmd_start`, `cmd_write`, `cmd_read`, `cmd_stop` in 1 each: command flags, sampled on handshake.
- `cmd_data` in 8: byte to write, MSB first.
- `cmd_nack` in 1: level the master drives in the ACK slot after a read (1 = NACK).
- `rsp_valid` out 1: one-cycle result pulse; there is no backpressure.
- `rsp_data` out 8: byte read, MSB first; holds its value until the next read completes.
- `rsp_nack` out 1: slave ACK-slot level on a write (1 = NACK).
- `rsp_error` out 1: command rejected or watchdog expired. Valid with `rsp_valid`.
- `phy_start_bit`, `phy_write_bit`, `phy_read_bit`, `phy_stop_bit` out 1: phy primitive strobes, at most one high at a time.
- `phy_tx_data` out 1: bit value for `phy_write_bit`.
- `phy_release_bus` out 1: forces the phy to idle.
- `phy_rx_data` in 1, `phy_state` in 5, `bus_control` in 1: phy status (ACTIVE=1, IDLE=0).
- `busy` out 1: equals `state!=IDLE`.

## Operation
- **States:** IDLE, CHECK, ISSUE, WAIT_DONE, RESP, ABORT.
- **IDLE → CHECK** on `cmd_valid & cmd_ready`. The controller latches the flags, `cmd_data` and `cmd_nack`, and clears bit counter `idx`.
- **CHECK (1 cycle)** → RESP with `rsp_error=1` and no strobe issued if:
  - `cmd_write & cmd_read`, or
  - no flag is set, or
  - `cmd_start=0` while `phy_state==IDLE` (no bus ownership).
  
  Otherwise → ISSUE.
- **Primitive order:** START (if flagged), then 8 data bits plus 1 ACK bit (if write/read), then STOP (if flagged).
  - Write byte: 8× write_bit with `phy_tx_data=data[7-idx]`, then 1× read_bit. `rsp_nack` ← `phy_rx_data`.
  - Read byte: 8× read_bit, shifting `phy_rx_data` into the LSB, then 1× write_bit with `phy_tx_data=cmd_nack`.
- **ISSUE:** hold the strobe (and `phy_tx_data`) until `phy_state` differs from its value when the strobe was raised (the phy has accepted it). Then drop the strobe in the next cycle → WAIT_DONE.
- **WAIT_DONE** completes when:
  - `phy_state==ACTIVE` for start/write/read primitives;
  - `phy_state==IDLE` for stop.
  
  Sample `phy_rx_data` on the completion cycle. On completion: advance to the next primitive → ISSUE, or if none remain → RESP.
- **RESP (1 cycle):** `rsp_valid=1` → IDLE.
- **Watchdog:** a 20-bit counter clears on entry to each ISSUE/WAIT_DONE. When it reaches `WATCHDOG`, go to ABORT.
- **ABORT (1 cycle):** `phy_release_bus=1`, strobes 0 → RESP with `rsp_error=1`.
- A START while the phy is ACTIVE is a repeated start. The phy handles it; the controller treats it like any other start.

## Timing
- **Reset values:**
  - `phy_release_bus=1` (registered; clears the first cycle after `rst` falls). This guarantees the phy is idle.
  - All other registered outputs are 0. `rsp_data=8'h00`.
  - State IDLE.
- **Reset mid-command:** takes effect at the next edge. Strobes are 0, the command is discarded, and no `rsp_valid` is produced.
- **Issue timing:** the first strobe rises 2 cycles after the handshake (CHECK, then ISSUE).
- **Errors:** a CHECK rejection produces `rsp_valid` exactly 2 cycles after the handshake.
- **Back-to-back:** `cmd_ready` returns the cycle after `rsp_valid`. Minimum command spacing is 3 cycles plus phy time.
- **Simultaneous events:** watchdog expiry in the same cycle as completion → completion wins.
- **Watchdog bound:** `WATCHDOG=0` behaves as 1 (expires after 1 waiting cycle).
- **`idx` range:** 0..8, no wrap. `idx==8` is the ACK slot.

## Test plan
- `cmd_start+cmd_write`, `cmd_data=0xA5`, slave ACKs, phy prescale 2 → SDA bits 1,0,1,0,0,1,0,1. Then `rsp_valid` with `rsp_nack=0`, `rsp_error=0`; `bus_control=1`.
- After the above: `cmd_read+cmd_stop`, `cmd_nack=1`, slave drives 0x3C → `rsp_data=0x3C`; master ACK slot SDA high; `phy_state` ends at 0, `bus_control=0`.
- `cmd_write` only, with the phy IDLE → `rsp_valid` with `rsp_error=1` two cycles after the handshake; no strobe ever high.
- `cmd_write+cmd_read` → `rsp_error=1`, no strobes. Then a valid `cmd_start` is accepted normally.
- `WATCHDOG=64`, slave holds SCL low during a write bit → one-cycle `phy_release_bus` pulse, `rsp_error=1`, `cmd_ready=1` afterwards, phy at IDLE.
- Assert `rst` during data bit 3 of a write → strobes 0 at the next edge, `phy_release_bus=1` through reset and for 1 cycle after, no `rsp_valid`. A new command is accepted afterwards.
